// File: rtl/dt_pkg.sv
// Shared node-word layout and walker FSM state for the decision-tree walker.
// Field widths cover the default configuration: 64 nodes, 7-bit leaf codes, feature index up to 15.
package dt_pkg;

  localparam int FEAT_W = 4;
  localparam int IDX_W  = 6;
  localparam int LEAF_W = 7;

  typedef struct packed {
    logic              is_leaf;
    logic [FEAT_W-1:0] feat;
    logic [IDX_W-1:0]  idx_f;
    logic [IDX_W-1:0]  idx_t;
    logic [LEAF_W-1:0] leaf_val;
  } dt_node_t;

  localparam int NODE_W = $bits(dt_node_t);

  // Field offsets inside the packed node word (LSB first).
  localparam int LEAF_VAL_LSB = 0;
  localparam int IDX_T_LSB    = LEAF_VAL_LSB + LEAF_W;
  localparam int IDX_F_LSB    = IDX_T_LSB + IDX_W;
  localparam int FEAT_LSB     = IDX_F_LSB + IDX_W;
  localparam int IS_LEAF_BIT  = FEAT_LSB + FEAT_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    HOLD = 2'd2
  } dt_state_e;

  function automatic logic [NODE_W-1:0] reset_node();
    return NODE_W'(1) << IS_LEAF_BIT;
  endfunction

endpackage

// File: rtl/dt_node_table.sv
// Register-file node table: synchronous write, asynchronous read, synchronous reset
// of every entry to a leaf with value 0.
module dt_node_table
  import dt_pkg::*;
#(
  parameter int N_NODES = 64,
  localparam int AW = $clog2(N_NODES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [NODE_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [NODE_W-1:0] rdata
);

  logic [NODE_W-1:0] mem_q [N_NODES];
  logic [NODE_W-1:0] mem_d [N_NODES];

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end else begin
      mem_d[waddr] = mem_q[waddr];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_NODES; i++) begin
        mem_q[i] <= reset_node();
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/dt_walker.sv
// Decision-tree walker: accepts a feature vector, follows the node table from the root
// one node per cycle, and presents the leaf code (or an error) until it is consumed.
module dt_walker
  import dt_pkg::*;
#(
  parameter int IN_W      = 7,
  parameter int OUT_W     = 7,
  parameter int N_NODES   = 64,
  parameter int MAX_DEPTH = 16,
  localparam int AW = $clog2(N_NODES),
  localparam int SW = $clog2(MAX_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [AW-1:0]     cfg_addr,
  input  logic [NODE_W-1:0] cfg_data,
  output logic              cfg_drop,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   inp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  outp,
  output logic              out_err
);

  dt_state_e         state_q, state_d;
  logic [IN_W-1:0]   inp_q, inp_d;
  logic [AW-1:0]     cur_q, cur_d;
  logic [SW-1:0]     step_q, step_d;
  logic [OUT_W-1:0]  outp_q, outp_d;
  logic              out_err_q, out_err_d;
  logic              out_valid_q, out_valid_d;
  logic              cfg_drop_q, cfg_drop_d;

  logic [NODE_W-1:0] rdata_s;
  dt_node_t          node_s;
  logic              tbl_we_s;
  logic              feat_bad_s;
  logic              sel_bit_s;

  // Writes land only while idle, so a walk always sees a stable table.
  assign tbl_we_s = cfg_we && (state_q == IDLE);

  dt_node_table #(.N_NODES(N_NODES)) u_table (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (tbl_we_s),
    .waddr (cfg_addr),
    .wdata (cfg_data),
    .raddr (cur_q),
    .rdata (rdata_s)
  );

  assign node_s     = dt_node_t'(rdata_s);
  assign feat_bad_s = 32'(node_s.feat) >= 32'(IN_W);
  assign sel_bit_s  = |(inp_q & (IN_W'(1) << node_s.feat));

  always_comb begin
    state_d     = state_q;
    inp_d       = inp_q;
    cur_d       = cur_q;
    step_d      = step_q;
    outp_d      = outp_q;
    out_err_d   = out_err_q;
    out_valid_d = 1'b0;
    cfg_drop_d  = cfg_we && (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          inp_d   = inp;
          cur_d   = '0;
          step_d  = '0;
          state_d = WALK;
        end else begin
          state_d = IDLE;
        end
      end
      WALK: begin
        if (node_s.is_leaf) begin
          outp_d    = OUT_W'(node_s.leaf_val);
          out_err_d = 1'b0;
          state_d   = HOLD;
        end else if (feat_bad_s || (step_q == SW'(MAX_DEPTH))) begin
          outp_d    = '0;
          out_err_d = 1'b1;
          state_d   = HOLD;
        end else begin
          cur_d  = sel_bit_s ? AW'(node_s.idx_t) : AW'(node_s.idx_f);
          step_d = step_q + SW'(1);
        end
      end
      HOLD: begin
        // out_valid rises one cycle into HOLD; out_ready is ignored until then.
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      inp_q       <= '0;
      cur_q       <= '0;
      step_q      <= '0;
      outp_q      <= '0;
      out_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
      cfg_drop_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      inp_q       <= inp_d;
      cur_q       <= cur_d;
      step_q      <= step_d;
      outp_q      <= outp_d;
      out_err_q   <= out_err_d;
      out_valid_q <= out_valid_d;
      cfg_drop_q  <= cfg_drop_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign outp      = outp_q;
  assign out_err   = out_err_q;
  assign cfg_drop  = cfg_drop_q;

endmodule
